// File: rtl/i2c_cmos_pkg.sv
// Shared types and constants for the PCF8583 CMOS RAM I2C responder.
package i2c_cmos_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_A,
    WORD,
    ACK_W,
    WDATA,
    ACK_D,
    RDATA,
    RACK
  } state_t;

  localparam logic [6:0] PCF8583_ADDR = 7'b1010000;
  localparam int         RAM_AW       = 8;
  localparam int         RAM_DEPTH    = 1 << RAM_AW;

endpackage

// File: rtl/i2c_cmos_ram.sv
// 256x8 dual-port CMOS RAM: port A serves the I2C FSM, port B the host.
// Registered read on both ports; the host write wins a same-address collision.
module cmos_ram
  import i2c_cmos_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAM_AW-1:0] addr_a,
  input  logic [7:0]        din_a,
  input  logic              we_a,
  output logic [7:0]        dout_a,
  input  logic [RAM_AW-1:0] addr_b,
  input  logic [7:0]        din_b,
  input  logic              we_b,
  output logic [7:0]        dout_b
);

  logic [7:0] mem [RAM_DEPTH];
  logic       drop_a;

  assign drop_a = we_b && (addr_a == addr_b);

  // Contents are battery-backed, so the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we_a && !drop_a) mem[addr_a] <= din_a;
    if (we_b)            mem[addr_b] <= din_b;
  end

  always_ff @(posedge clk) begin
    dout_a <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dout_b <= 8'h00;
    else        dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/i2c_cmos.sv
// PCF8583 CMOS RAM responder on the IOC bit-banged I2C bus, with a host
// load/save port into the same RAM.
module i2c_cmos
  import i2c_cmos_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = PCF8583_ADDR
) (
  input  logic       clkcpu,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_din,
  input  logic       host_we,
  output logic [7:0] host_dout,
  output logic       busy_o,
  output state_t     fsm_state,
  output logic [7:0] pointer
);

  // [0] first sync stage, [1] synchronized value, [2] previous sample
  logic [2:0] scl_sh, sda_sh;
  logic       scl_rise, scl_fall, start_ev, stop_ev;

  state_t     state, state_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [7:0] shreg, sh_n;
  logic [7:0] ptr, ptr_n;
  logic       sda_q, sda_n;
  logic       busy_q, busy_n;
  logic       ram_we;
  logic [7:0] ram_rdata;

  always_ff @(posedge clkcpu) begin
    if (!rst_n) begin
      scl_sh <= 3'b111;
      sda_sh <= 3'b111;
    end else begin
      scl_sh <= {scl_sh[1:0], scl_i};
      sda_sh <= {sda_sh[1:0], sda_i};
    end
  end

  assign scl_rise = scl_sh[1] & ~scl_sh[2];
  assign scl_fall = ~scl_sh[1] & scl_sh[2];
  assign start_ev = scl_sh[1] & scl_sh[2] & sda_sh[2] & ~sda_sh[1];
  assign stop_ev  = scl_sh[1] & scl_sh[2] & ~sda_sh[2] & sda_sh[1];

  always_ff @(posedge clkcpu) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      ptr     <= 8'h00;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shreg   <= sh_n;
      ptr     <= ptr_n;
      sda_q   <= sda_n;
      busy_q  <= busy_n;
    end
  end

  // SCL edges are handled before START/STOP so a simultaneous SDA change is ignored.
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    ptr_n   = ptr;
    sda_n   = sda_q;
    busy_n  = busy_q;
    ram_we  = 1'b0;
    if (scl_rise) begin
      case (state)
        ADDR, WORD, WDATA: begin
          if (bit_cnt < 4'd8) begin
            sh_n  = {shreg[6:0], sda_sh[1]};
            cnt_n = bit_cnt + 4'd1;
          end
        end
        RDATA: cnt_n = bit_cnt + 4'd1;
        RACK: begin
          if (bit_cnt == 4'd8) begin
            if (!sda_sh[1]) begin
              ptr_n = ptr + 8'd1;
              cnt_n = 4'd9;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ADDR: begin
          if (bit_cnt == 4'd8) begin
            cnt_n = 4'd0;
            if (shreg[7:1] == DEV_ADDR) begin
              state_n = ACK_A;
              sda_n   = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        ACK_A: begin
          cnt_n = 4'd0;
          if (shreg[0]) begin
            state_n = RDATA;
            sh_n    = ram_rdata;
            sda_n   = ram_rdata[7];
          end else begin
            state_n = WORD;
            sda_n   = 1'b1;
          end
        end
        WORD: begin
          if (bit_cnt == 4'd8) begin
            ptr_n   = shreg;
            state_n = ACK_W;
            sda_n   = 1'b0;
            cnt_n   = 4'd0;
          end
        end
        ACK_W: begin
          state_n = WDATA;
          sda_n   = 1'b1;
          cnt_n   = 4'd0;
        end
        WDATA: begin
          if (bit_cnt == 4'd8) begin
            state_n = ACK_D;
            sda_n   = 1'b0;
            cnt_n   = 4'd0;
          end
        end
        ACK_D: begin
          ram_we  = 1'b1;
          ptr_n   = ptr + 8'd1;
          state_n = WDATA;
          sda_n   = 1'b1;
          cnt_n   = 4'd0;
        end
        RDATA: begin
          if (bit_cnt == 4'd8) begin
            state_n = RACK;
            sda_n   = 1'b1;
          end else begin
            sh_n  = {shreg[6:0], 1'b0};
            sda_n = shreg[6];
          end
        end
        RACK: begin
          // bit_cnt 9 marks a master ACK; the reloaded byte is already fetched
          if (bit_cnt == 4'd9) begin
            state_n = RDATA;
            sh_n    = ram_rdata;
            sda_n   = ram_rdata[7];
            cnt_n   = 4'd0;
          end
        end
        default: ;
      endcase
    end else if (start_ev) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      sda_n   = 1'b1;
      busy_n  = 1'b1;
    end else if (stop_ev) begin
      state_n = IDLE;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end
  end

  cmos_ram u_ram (
    .clk    (clkcpu),
    .rst_n  (rst_n),
    .addr_a (ptr),
    .din_a  (shreg),
    .we_a   (ram_we),
    .dout_a (ram_rdata),
    .addr_b (host_addr),
    .din_b  (host_din),
    .we_b   (host_we),
    .dout_b (host_dout)
  );

  assign sda_o     = sda_q;
  assign busy_o    = busy_q;
  assign fsm_state = state;
  assign pointer   = ptr;

endmodule

// File: tb/tb_i2c_cmos.sv
// Bench for i2c_cmos: bit-banged I2C master tasks, a RAM/pointer reference
// model, directed scenarios and a short randomized transaction mix.
module tb_i2c_cmos;
  import i2c_cmos_pkg::*;

  localparam int Q = 50;  // quarter SCL period in clkcpu cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_o, busy;
  logic [7:0] host_addr = 8'h00, host_din = 8'h00, host_dout, pointer;
  logic       host_we = 1'b0;
  state_t     fsm_state;
  wire        sda_bus = sda_drv & sda_o;

  int total = 0;
  int bad = 0;
  int low_cnt = 0;
  bit mon_en = 1'b0;

  logic [7:0] mem_m [256];
  logic [7:0] ptr_m = 8'h00;
  logic [7:0] exp_q [$];

  i2c_cmos dut (
    .clkcpu    (clk),
    .rst_n     (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_drv),
    .sda_o     (sda_o),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_we   (host_we),
    .host_dout (host_dout),
    .busy_o    (busy),
    .fsm_state (fsm_state),
    .pointer   (pointer)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && !sda_o) low_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_addr = a; host_din = d; host_we = 1'b1;
    tick(1);
    host_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic host_check(input string tag, input logic [7:0] a);
    host_addr = a;
    tick(1);
    check(tag, host_dout, mem_m[a]);
  endtask

  task automatic bus_start;
    sda_drv = 1'b1; tick(Q);
    scl = 1'b1;     tick(Q);
    sda_drv = 1'b0; tick(Q);
    scl = 1'b0;     tick(Q);
  endtask

  task automatic bus_stop;
    sda_drv = 1'b0; tick(Q);
    scl = 1'b1;     tick(Q);
    sda_drv = 1'b1; tick(Q);
  endtask

  // collide: the host writes caddr on exactly the cycle the I2C byte commits
  task automatic send_byte(input logic [7:0] d, input bit collide,
                           input logic [7:0] caddr, input logic [7:0] cdin,
                           output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = d[i]; tick(Q);
      scl = 1'b1;     tick(2 * Q);
      scl = 1'b0;     tick(Q);
    end
    sda_drv = 1'b1; tick(Q);
    scl = 1'b1;     tick(Q);
    ack = sda_bus;  tick(Q);
    scl = 1'b0;
    if (collide) begin
      repeat (2) @(posedge clk);
      #1;
      host_addr = caddr; host_din = cdin; host_we = 1'b1;
      @(posedge clk);
      #1;
      host_we = 1'b0;
      tick(Q - 3);
    end else begin
      tick(Q);
    end
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      scl = 1'b1; tick(Q);
      d[i] = sda_bus; tick(Q);
      scl = 1'b0;
    end
    tick(Q);
    sda_drv = ack; tick(Q);
    scl = 1'b1;    tick(2 * Q);
    scl = 1'b0;    tick(Q);
    sda_drv = 1'b1;
  endtask

  // transaction-level helpers that keep the reference model in step
  task automatic set_ptr(input logic [7:0] word);
    logic ack;
    bus_start;
    send_byte(8'hA0, 1'b0, 8'h00, 8'h00, ack); check("addr_w_ack", ack, 0);
    send_byte(word, 1'b0, 8'h00, 8'h00, ack);  check("word_ack", ack, 0);
    ptr_m = word;
  endtask

  task automatic read_sel;
    logic ack;
    bus_start;
    send_byte(8'hA1, 1'b0, 8'h00, 8'h00, ack); check("addr_r_ack", ack, 0);
  endtask

  task automatic put_byte(input logic [7:0] d);
    logic ack;
    send_byte(d, 1'b0, 8'h00, 8'h00, ack);
    check("wdata_ack", ack, 0);
    mem_m[ptr_m] = d;
    ptr_m = ptr_m + 8'd1;
  endtask

  task automatic get_byte(input logic ack);
    logic [7:0] d;
    exp_q.push_back(mem_m[ptr_m]);
    recv_byte(ack, d);
    check("rdata", d, exp_q.pop_front());
    if (!ack) ptr_m = ptr_m + 8'd1;
  endtask

  initial begin
    logic       ack;
    logic [7:0] a;
    int         n, kind, lows;

    // reset
    tick(3);
    check("rst_sda", sda_o, 1);
    check("rst_busy", busy, 0);
    check("rst_ptr", pointer, 0);
    check("rst_state", fsm_state, IDLE);
    check("rst_hdout", host_dout, 0);
    rst_n = 1'b1; tick(2);
    host_write(8'h05, 8'h77);
    rst_n = 1'b0; tick(2);
    rst_n = 1'b1; tick(1);
    host_check("ram_survives_rst", 8'h05);
    check("ram_survives_rst_k", host_dout, 8'h77);

    // write
    set_ptr(8'h10);
    put_byte(8'h5A);
    put_byte(8'hC3);
    check("wr_busy_mid", busy, 1);
    bus_stop;
    check("wr_busy_stop", busy, 0);
    check("wr_ptr", pointer, ptr_m);
    host_check("wr_10", 8'h10);
    check("wr_10_k", host_dout, 8'h5A);
    host_check("wr_11", 8'h11);
    check("wr_11_k", host_dout, 8'hC3);

    // random read with repeated START
    host_write(8'h40, 8'h12);
    host_write(8'h41, 8'h34);
    set_ptr(8'h40);
    read_sel;
    get_byte(1'b0);
    get_byte(1'b1);
    check("rd_sda_after_nack", sda_o, 1);
    check("rd_state_after_nack", fsm_state, IDLE);
    bus_stop;
    check("rd_ptr", pointer, ptr_m);

    // pointer wrap
    set_ptr(8'hFF);
    put_byte(8'hAA);
    put_byte(8'hBB);
    bus_stop;
    host_check("wrap_ff", 8'hFF);
    host_check("wrap_00", 8'h00);
    check("wrap_ptr", pointer, 8'h01);

    // address mismatch
    lows = low_cnt;
    mon_en = 1'b1;
    bus_start;
    send_byte(8'hA2, 1'b0, 8'h00, 8'h00, ack);
    check("nomatch_ack", ack, 1);
    bus_stop;
    mon_en = 1'b0;
    check("nomatch_sda_low", low_cnt - lows, 0);
    check("nomatch_ptr", pointer, ptr_m);
    host_check("nomatch_ram", 8'h10);

    // host/I2C write collision: host value must survive
    set_ptr(8'h20);
    send_byte(8'h11, 1'b1, 8'h20, 8'h99, ack);
    check("coll_ack", ack, 0);
    mem_m[8'h20] = 8'h99;
    ptr_m = ptr_m + 8'd1;
    put_byte(8'h22);
    bus_stop;
    host_check("coll_20", 8'h20);
    check("coll_20_k", host_dout, 8'h99);
    host_check("coll_21", 8'h21);

    // abort by reset while the responder drives 0
    host_write(8'h60, 8'h34);
    set_ptr(8'h60);
    read_sel;
    check("abort_driving", sda_o, 0);
    rst_n = 1'b0; tick(1);
    check("abort_sda", sda_o, 1);
    check("abort_state", fsm_state, IDLE);
    check("abort_busy", busy, 0);
    rst_n = 1'b1; ptr_m = 8'h00;
    check("abort_ptr", pointer, ptr_m);
    bus_stop;
    set_ptr(8'h70);
    put_byte(8'h3C);
    bus_stop;
    host_check("post_abort_70", 8'h70);

    // randomized mix against the model
    for (int i = 0; i < 256; i++) host_write(8'(i), 8'($urandom_range(0, 255)));
    for (int t = 0; t < 4; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 2);
      if (kind <= 1) begin
        set_ptr(8'($urandom_range(0, 255)));
        for (int k = 0; k < n; k++) put_byte(8'($urandom_range(0, 255)));
      end else if (kind == 2) begin
        if ($urandom_range(0, 1) == 1) set_ptr(8'($urandom_range(0, 255)));
        read_sel;
        for (int k = 0; k < n; k++) get_byte((k == n - 1) ? 1'b1 : 1'b0);
      end else begin
        do a = 8'($urandom_range(0, 255)); while (a[7:1] == PCF8583_ADDR);
        bus_start;
        send_byte(a, 1'b0, 8'h00, 8'h00, ack);
        check("rnd_nomatch_ack", ack, 1);
      end
      bus_stop;
      check("rnd_ptr", pointer, ptr_m);
      check("rnd_busy", busy, 0);
      host_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 256; i++) host_check("rnd_ram", 8'(i));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
